// File: rtl/lsu_pkg.sv
// Shared types for the load/store unit: size encodings, FSM states, latched request and the alignment rule.
package lsu_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_t;

  typedef enum logic [2:0] {
    IDLE,
    LD_RD,
    LD_RET,
    ST_WR,
    RMW_RD,
    RMW_WR,
    ERR
  } state_t;

  typedef struct packed {
    logic        store;
    size_t       size;
    logic        isUnsigned;
    logic [31:0] storeData;
  } request_t;

  // A request faults on the reserved size or when it is not naturally aligned.
  function automatic logic isMisaligned(input size_t size, input logic [1:0] addrLow);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_HALF: bad = addrLow[0];
      SZ_WORD: bad = (addrLow != 2'b00);
      SZ_RSVD: bad = 1'b1;
      default: bad = 1'b0;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/load_store_unit_if.sv
// Core-side request/response bundle of the load/store unit.
interface load_store_unit_if;
  logic        Req;
  logic        Store;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [31:0] Addr;
  logic [31:0] StoreData;
  logic [31:0] LoadData;
  logic        Done;
  logic        Fault;
  logic        Busy;

  modport master (
    output Req, Store, Size, Unsigned, Addr, StoreData,
    input  LoadData, Done, Fault, Busy
  );

  modport slave (
    input  Req, Store, Size, Unsigned, Addr, StoreData,
    output LoadData, Done, Fault, Busy
  );
endinterface

// File: rtl/lsu_lane_align.sv
// Lane extraction/extension for loads and lane merge for sub-word stores.
// Big-endian lanes by default; define LSU_LITTLE_ENDIAN_EN for little-endian lanes.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  size_t       size,
  input  logic        isUnsigned,
  input  logic [1:0]  byteOffset,
  input  logic [31:0] readWord,
  input  logic [31:0] storeValue,
  output logic [31:0] loadValue,
  output logic [31:0] mergedWord
);

  logic [4:0]  byteShift;
  logic [4:0]  halfShift;
  logic [4:0]  laneShift;
  logic [31:0] shifted;
  logic [31:0] laneMask;

  always_comb begin
`ifdef LSU_LITTLE_ENDIAN_EN
    byteShift = {byteOffset, 3'b000};
    halfShift = byteOffset[1] ? 5'd16 : 5'd0;
`else
    byteShift = {~byteOffset, 3'b000};
    halfShift = byteOffset[1] ? 5'd0 : 5'd16;
`endif
    laneShift = 5'd0;
    laneMask  = 32'hFFFF_FFFF;
    loadValue = readWord;
    shifted   = readWord;
    case (size)
      SZ_BYTE: begin
        laneShift = byteShift;
        shifted   = readWord >> laneShift;
        laneMask  = 32'h0000_00FF << laneShift;
        loadValue = {{24{~isUnsigned & shifted[7]}}, shifted[7:0]};
      end
      SZ_HALF: begin
        laneShift = halfShift;
        shifted   = readWord >> laneShift;
        laneMask  = 32'h0000_FFFF << laneShift;
        loadValue = {{16{~isUnsigned & shifted[15]}}, shifted[15:0]};
      end
      default: ;
    endcase
    mergedWord = (readWord & ~laneMask) | ((storeValue << laneShift) & laneMask);
  end

endmodule

// File: rtl/load_store_unit.sv
// Byte/half/word load-store unit in front of a word-wide data memory; Busy stalls the core per access.
// Lane order set in lsu_lane_align (LSU_LITTLE_ENDIAN_EN selects little-endian).
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDSIZE  = 6,
  parameter int MEMWIDTH = 32
) (
  input  logic               Clock,
  input  logic               Reset,
  load_store_unit_if.slave   core,
  output logic [ADDSIZE-1:0] MemAddress,
  output logic [31:0]        MemWriteData,
  output logic               MemoryRead,
  output logic               MemoryWrite,
  input  logic [31:0]        MemReadData
);

  generate
    if (MEMWIDTH != 32) begin : gBadWidth
      $error("load_store_unit supports MEMWIDTH = 32 only");
    end
  endgenerate

  state_t             state;
  request_t           req;
  logic [ADDSIZE+1:0] reqAddr;
  logic [31:0]        loadReg;
  logic               doneReg;
  logic               faultReg;
  logic [31:0]        loadValue;
  logic [31:0]        mergedWord;

  lsu_lane_align u_align (
    .size       (req.size),
    .isUnsigned (req.isUnsigned),
    .byteOffset (reqAddr[1:0]),
    .readWord   (MemReadData),
    .storeValue (req.storeData),
    .loadValue  (loadValue),
    .mergedWord (mergedWord)
  );

  // Requests are only looked at in IDLE, so a held Req starts exactly one access per acceptance.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state    <= IDLE;
      req      <= '0;
      reqAddr  <= '0;
      loadReg  <= '0;
      doneReg  <= 1'b0;
      faultReg <= 1'b0;
    end else begin
      doneReg  <= 1'b0;
      faultReg <= 1'b0;
      case (state)
        IDLE: begin
          if (core.Req) begin
            req.store      <= core.Store;
            req.size       <= size_t'(core.Size);
            req.isUnsigned <= core.Unsigned;
            req.storeData  <= core.StoreData;
            reqAddr        <= core.Addr[ADDSIZE+1:0];
            if (isMisaligned(size_t'(core.Size), core.Addr[1:0]))
              state <= ERR;
            else if (!core.Store)
              state <= LD_RD;
            else if (size_t'(core.Size) == SZ_WORD)
              state <= ST_WR;
            else
              state <= RMW_RD;
          end
        end
        LD_RD:  state <= LD_RET;
        LD_RET: begin
          loadReg <= loadValue;
          doneReg <= 1'b1;
          state   <= IDLE;
        end
        ST_WR: begin
          doneReg <= 1'b1;
          state   <= IDLE;
        end
        RMW_RD: state <= RMW_WR;
        RMW_WR: begin
          doneReg <= 1'b1;
          state   <= IDLE;
        end
        ERR: begin
          doneReg  <= 1'b1;
          faultReg <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Strobes are gated by Reset so a reset cycle can never let the negedge write land.
  always_comb begin
    MemoryRead   = !Reset && (state == LD_RD || state == RMW_RD);
    MemoryWrite  = !Reset && (state == ST_WR || state == RMW_WR);
    MemAddress   = (state == IDLE || state == ERR) ? '0 : reqAddr[ADDSIZE+1:2];
    MemWriteData = '0;
    if (state == ST_WR)
      MemWriteData = req.storeData;
    else if (state == RMW_WR)
      MemWriteData = mergedWord;
  end

  assign core.Busy     = (state != IDLE);
  assign core.LoadData = loadReg;
  assign core.Done     = doneReg;
  assign core.Fault    = faultReg;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: byte-addressed reference memory, directed scenarios and randomized accesses.
// Honours LSU_LITTLE_ENDIAN_EN in its reference model.
module tb_load_store_unit;

  localparam int ADDSIZE = 6;
  localparam int TIMEOUT = 20;

  logic               Clock = 1'b0;
  logic               Reset;
  logic [ADDSIZE-1:0] MemAddress;
  logic [31:0]        MemWriteData;
  logic [31:0]        MemReadData;
  logic               MemoryRead;
  logic               MemoryWrite;

  load_store_unit_if core ();

  load_store_unit #(.ADDSIZE(ADDSIZE), .MEMWIDTH(32)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .core         (core),
    .MemAddress   (MemAddress),
    .MemWriteData (MemWriteData),
    .MemoryRead   (MemoryRead),
    .MemoryWrite  (MemoryWrite),
    .MemReadData  (MemReadData)
  );

  always #5 Clock = ~Clock;

  logic [31:0] mem [64];
  logic [7:0]  refBytes [256];
  logic [31:0] lastLoad;
  int testsRun    = 0;
  int testsFailed = 0;
  int readCount   = 0;
  int writeCount  = 0;
  int busyCount   = 0;
  int doneCount   = 0;

  always @(posedge Clock) begin
    if (MemoryRead) MemReadData <= mem[MemAddress];
  end

  // Memory writes land on negedge; the strobe counters sample mid-cycle alongside them.
  always @(negedge Clock) begin
    if (MemoryWrite) begin
      mem[MemAddress] = MemWriteData;
      writeCount++;
    end
    if (MemoryRead) readCount++;
    if (core.Busy) busyCount++;
    if (core.Done) doneCount++;
  end

  function automatic logic [31:0] refWord(input int w);
    logic [31:0] v;
    for (int i = 0; i < 4; i++) begin
`ifdef LSU_LITTLE_ENDIAN_EN
      v[8*i +: 8] = refBytes[4*w+i];
`else
      v[8*(3-i) +: 8] = refBytes[4*w+i];
`endif
    end
    return v;
  endfunction

  task automatic setWord(input int w, input logic [31:0] v);
    mem[w] = v;
    for (int i = 0; i < 4; i++) begin
`ifdef LSU_LITTLE_ENDIAN_EN
      refBytes[4*w+i] = v[8*i +: 8];
`else
      refBytes[4*w+i] = v[8*(3-i) +: 8];
`endif
    end
  endtask

  // Reference: memory as a byte array, accesses as runs of consecutive bytes.
  task automatic modelAccess(input logic st, input logic [1:0] sz, input logic uns,
                             input logic [31:0] a, input logic [31:0] d,
                             output logic [31:0] expLoad, output logic expFault, output int expLat);
    int base;
    int n;
    logic [31:0] v;
    base = int'(a[7:0]);
    n = 1 << sz;
    expFault = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00);
    if (expFault) begin
      expLat = 1;
    end else if (st) begin
      for (int i = 0; i < n; i++) begin
`ifdef LSU_LITTLE_ENDIAN_EN
        refBytes[base+i] = d[8*i +: 8];
`else
        refBytes[base+i] = d[8*(n-1-i) +: 8];
`endif
      end
      expLat = (n == 4) ? 1 : 2;
    end else begin
      v = '0;
      for (int i = 0; i < n; i++) begin
`ifdef LSU_LITTLE_ENDIAN_EN
        v[8*i +: 8] = refBytes[base+i];
`else
        v = {v[23:0], refBytes[base+i]};
`endif
      end
      if (n < 4 && !uns && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      lastLoad = v;
      expLat = 2;
    end
    expLoad = lastLoad;
  endtask

  task automatic runAccess(input logic st, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] d,
                           output int latency, output logic [31:0] ld, output logic flt);
    @(negedge Clock);
    core.Req = 1'b1; core.Store = st; core.Size = sz;
    core.Unsigned = uns; core.Addr = a; core.StoreData = d;
    @(posedge Clock);
    #1 core.Req = 1'b0;
    latency = 0;
    do begin
      @(posedge Clock);
      #1 latency++;
    end while (!core.Done && latency < TIMEOUT);
    ld  = core.LoadData;
    flt = core.Fault;
  endtask

  task automatic test_reset();
    Reset = 1'b1;
    core.Req = 1'b0; core.Store = 1'b0; core.Size = 2'b00;
    core.Unsigned = 1'b0; core.Addr = '0; core.StoreData = '0;
    repeat (2) @(posedge Clock);
    @(negedge Clock);
    testsRun++;
    if ({core.Done, core.Fault, core.Busy, MemoryRead, MemoryWrite} !== 5'b0) begin
      testsFailed++;
      $display("[TB] FAIL resetFlags: got %b expected 00000",
               {core.Done, core.Fault, core.Busy, MemoryRead, MemoryWrite});
    end
    testsRun++;
    if (core.LoadData !== 32'h0 || MemAddress !== '0 || MemWriteData !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL resetData: got LoadData=%h MemAddress=%h MemWriteData=%h expected zeros",
               core.LoadData, MemAddress, MemWriteData);
    end
    Reset = 1'b0;
  endtask

  task automatic test_word_access();
    logic [31:0] eL, ld;
    logic eF, flt;
    int eLat, lat, b;
    modelAccess(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, eL, eF, eLat);
    b = busyCount;
    runAccess(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, lat, ld, flt);
    testsRun++;
    if (lat != 1 || flt !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL wordStoreDone: got latency=%0d fault=%b expected 1/0", lat, flt);
    end
    testsRun++;
    if (busyCount - b != 1) begin
      testsFailed++;
      $display("[TB] FAIL wordStoreBusy: got %0d busy cycles expected 1", busyCount - b);
    end
    testsRun++;
    if (mem[4] !== refWord(4)) begin
      testsFailed++;
      $display("[TB] FAIL wordStoreMem: got %h expected %h", mem[4], refWord(4));
    end
    modelAccess(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, eL, eF, eLat);
    runAccess(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, ld, flt);
    testsRun++;
    if (lat != 2 || ld !== 32'hDEAD_BEEF || ld !== eL) begin
      testsFailed++;
      $display("[TB] FAIL wordLoad: got latency=%0d data=%h expected 2/DEADBEEF", lat, ld);
    end
  endtask

  task automatic test_byte_access();
    logic [31:0] eL, ld;
    logic eF, flt;
    int eLat, lat;
    modelAccess(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00A5, eL, eF, eLat);
    runAccess(1'b1, 2'd0, 1'b0, 32'h11, 32'h0000_00A5, lat, ld, flt);
    testsRun++;
    if (lat != 2 || mem[4] !== refWord(4)) begin
      testsFailed++;
      $display("[TB] FAIL byteStore: got latency=%0d word=%h expected 2/%h", lat, mem[4], refWord(4));
    end
    modelAccess(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, eL, eF, eLat);
    runAccess(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, lat, ld, flt);
    testsRun++;
    if (ld !== 32'hFFFF_FFA5 || ld !== eL) begin
      testsFailed++;
      $display("[TB] FAIL byteLoadSigned: got %h expected FFFFFFA5", ld);
    end
    modelAccess(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, eL, eF, eLat);
    runAccess(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, lat, ld, flt);
    testsRun++;
    if (ld !== 32'h0000_00A5 || ld !== eL) begin
      testsFailed++;
      $display("[TB] FAIL byteLoadUnsigned: got %h expected 000000A5", ld);
    end
  endtask

  task automatic test_half_access();
    logic [31:0] eL, ld;
    logic eF, flt;
    int eLat, lat;
    modelAccess(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_8234, eL, eF, eLat);
    runAccess(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_8234, lat, ld, flt);
    testsRun++;
    if (lat != 2 || mem[4] !== refWord(4)) begin
      testsFailed++;
      $display("[TB] FAIL halfStore: got latency=%0d word=%h expected 2/%h", lat, mem[4], refWord(4));
    end
    modelAccess(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, eL, eF, eLat);
    runAccess(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, lat, ld, flt);
    testsRun++;
    if (ld !== 32'hFFFF_8234 || ld !== eL) begin
      testsFailed++;
      $display("[TB] FAIL halfLoadSigned: got %h expected FFFF8234", ld);
    end
    modelAccess(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, eL, eF, eLat);
    runAccess(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, lat, ld, flt);
    testsRun++;
    if (ld !== 32'h0000_8234 || ld !== eL) begin
      testsFailed++;
      $display("[TB] FAIL halfLoadUnsigned: got %h expected 00008234", ld);
    end
  endtask

  task automatic test_faults();
    logic [31:0] eL, ld;
    logic eF, flt;
    int eLat, lat, r, w;
    logic [1:0]  fSize [3];
    logic        fStore [3];
    logic [31:0] fAddr [3];
    fSize = '{2'd1, 2'd2, 2'd3};
    fStore = '{1'b0, 1'b1, 1'b0};
    fAddr = '{32'h13, 32'h02, 32'h10};
    for (int k = 0; k < 3; k++) begin
      r = readCount; w = writeCount;
      modelAccess(fStore[k], fSize[k], 1'b0, fAddr[k], 32'h1234_5678, eL, eF, eLat);
      runAccess(fStore[k], fSize[k], 1'b0, fAddr[k], 32'h1234_5678, lat, ld, flt);
      testsRun++;
      if (lat != 1 || flt !== 1'b1 || ld !== eL) begin
        testsFailed++;
        $display("[TB] FAIL fault%0d: got latency=%0d fault=%b data=%h expected 1/1/%h", k, lat, flt, ld, eL);
      end
      testsRun++;
      if (readCount != r || writeCount != w || mem[0] !== refWord(0) || mem[4] !== refWord(4)) begin
        testsFailed++;
        $display("[TB] FAIL faultNoAccess%0d: got reads=%0d writes=%0d expected 0/0", k, readCount - r, writeCount - w);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] eL1, eL2;
    logic eF;
    int eLat, lat, r;
    r = readCount;
    modelAccess(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, eL1, eF, eLat);
    @(negedge Clock);
    core.Req = 1'b1; core.Store = 1'b0; core.Size = 2'd2;
    core.Unsigned = 1'b0; core.Addr = 32'h10; core.StoreData = 32'h0;
    @(posedge Clock);
    lat = 0;
    do begin
      @(posedge Clock);
      #1 lat++;
    end while (!core.Done && lat < TIMEOUT);
    testsRun++;
    if (lat != 2 || core.LoadData !== eL1) begin
      testsFailed++;
      $display("[TB] FAIL heldReqLoad: got latency=%0d data=%h expected 2/%h", lat, core.LoadData, eL1);
    end
    modelAccess(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, eL2, eF, eLat);
    core.Size = 2'd1; core.Unsigned = 1'b1; core.Addr = 32'h12;
    @(posedge Clock);
    #1 core.Req = 1'b0;
    testsRun++;
    if (core.Busy !== 1'b1) begin
      testsFailed++;
      $display("[TB] FAIL backToBackAccept: got Busy=%b expected 1", core.Busy);
    end
    lat = 0;
    do begin
      @(posedge Clock);
      #1 lat++;
    end while (!core.Done && lat < TIMEOUT);
    testsRun++;
    if (lat != 2 || core.LoadData !== eL2 || readCount - r != 2) begin
      testsFailed++;
      $display("[TB] FAIL backToBackLoad: got latency=%0d data=%h reads=%0d expected 2/%h/2",
               lat, core.LoadData, readCount - r, eL2);
    end
  endtask

  task automatic test_reset_midflight();
    int r, w, d;
    @(negedge Clock);
    core.Req = 1'b1; core.Store = 1'b1; core.Size = 2'd0;
    core.Unsigned = 1'b0; core.Addr = 32'h11; core.StoreData = 32'h0000_005A;
    @(posedge Clock);
    #1 core.Req = 1'b0;
    Reset = 1'b1;
    r = readCount; w = writeCount; d = doneCount;
    @(negedge Clock);
    testsRun++;
    if (MemoryRead !== 1'b0 || MemoryWrite !== 1'b0) begin
      testsFailed++;
      $display("[TB] FAIL resetStrobes: got read=%b write=%b expected 0/0", MemoryRead, MemoryWrite);
    end
    @(posedge Clock);
    #1 Reset = 1'b0;
    testsRun++;
    if (core.Busy !== 1'b0 || core.Done !== 1'b0 || core.LoadData !== 32'h0) begin
      testsFailed++;
      $display("[TB] FAIL resetMidflight: got Busy=%b Done=%b LoadData=%h expected 0/0/0",
               core.Busy, core.Done, core.LoadData);
    end
    lastLoad = 32'h0;
    repeat (3) @(posedge Clock);
    #1;
    testsRun++;
    if (writeCount != w || readCount != r || doneCount != d || mem[4] !== refWord(4)) begin
      testsFailed++;
      $display("[TB] FAIL resetNoWrite: got writes=%0d dones=%0d word=%h expected 0/0/%h",
               writeCount - w, doneCount - d, mem[4], refWord(4));
    end
  endtask

  task automatic test_random();
    logic [31:0] eL, ld, a, d;
    logic eF, flt, st, uns;
    logic [1:0] sz;
    int eLat, lat;
    for (int k = 0; k < 60; k++) begin
      a = $urandom();
      a[7:5] = 3'b000;
      d = $urandom();
      st = 1'($urandom_range(0, 1));
      uns = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      modelAccess(st, sz, uns, a, d, eL, eF, eLat);
      runAccess(st, sz, uns, a, d, lat, ld, flt);
      testsRun++;
      if (lat != eLat || flt !== eF || ld !== eL) begin
        testsFailed++;
        $display("[TB] FAIL random%0d: st=%b sz=%0d addr=%h got lat=%0d fault=%b data=%h expected %0d/%b/%h",
                 k, st, sz, a, lat, flt, ld, eLat, eF, eL);
      end
    end
    for (int w = 0; w < 64; w++) begin
      testsRun++;
      if (mem[w] !== refWord(w)) begin
        testsFailed++;
        $display("[TB] FAIL memWord%0d: got %h expected %h", w, mem[w], refWord(w));
      end
    end
  endtask

  initial begin
    lastLoad = 32'h0;
    for (int w = 0; w < 64; w++) setWord(w, $urandom());
    test_reset();
    test_word_access();
    test_byte_access();
    test_half_access();
    test_faults();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
